// File: rtl/ibex_rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_arb_pkg
// Brief    : Shared constants, address-width helper and write-stage struct
//            for the register-file write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ibex_rf_arb_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned RegDataW  = 32;
    localparam int unsigned NumReqMax = 4;

    function automatic int unsigned addr_width(input bit rv32e);
        return rv32e ? 32'd4 : 32'd5;
    endfunction

    // The struct fixes the data width, so the arbiter's DataWidth must equal RegDataW.
    typedef struct packed {
        logic                we;
        logic [RegAddrW-1:0] waddr;
        logic [RegDataW-1:0] wdata;
    } rf_wr_t;

endpackage
`default_nettype wire

// File: rtl/ibex_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rr_arbiter
// Brief    : Combinational round-robin pick: first valid index at or after
//            rr_i, searching upward with wrap. Pointer lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rr_arbiter
    import ibex_rf_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                 valid_i,
    input  logic [$clog2(NumReqMax)-1:0] rr_i,
    output logic [N-1:0]                 gnt_o,
    output logic [$clog2(NumReqMax)-1:0] gnt_idx_o
);

    localparam int unsigned c_IDX_W = $clog2(NumReqMax);

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        // Walk from the farthest candidate back to rr_i so the nearest valid one sticks.
        for (int i = N - 1; i >= 0; i--) begin
            for (int j = 0; j < N; j++) begin
                if ((j == (int'(rr_i) + i) % N) && valid_i[j]) begin
                    gnt_o     = '0;
                    gnt_o[j]  = 1'b1;
                    gnt_idx_o = c_IDX_W'(j);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ibex_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_write_arbiter
// Brief    : Round-robin sharing of the RF write port with a registered
//            output stage, a commit stage and read-port bypass.
// Revision : 1.0 - initial release
// ============================================================================
module ibex_rf_write_arbiter
    import ibex_rf_arb_pkg::*;
#(
    parameter int unsigned NumReq    = 2,
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*RegAddrW-1:0]    req_waddr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic                          rf_we_o,
    output logic [RegAddrW-1:0]           rf_waddr_o,
    output logic [DataWidth-1:0]          rf_wdata_o,
    input  logic [RegAddrW-1:0]           raddr_a_i,
    input  logic [RegAddrW-1:0]           raddr_b_i,
    input  logic [DataWidth-1:0]          rf_rdata_a_i,
    input  logic [DataWidth-1:0]          rf_rdata_b_i,
    output logic [DataWidth-1:0]          rdata_a_o,
    output logic [DataWidth-1:0]          rdata_b_o,
    output logic                          illegal_waddr_o
);

    localparam int unsigned c_IDX_W  = $clog2(NumReqMax);
    localparam int unsigned c_ADDR_W = addr_width(RV32E);

    logic [c_IDX_W-1:0]   r_rr_q;
    rf_wr_t               r_out;
    rf_wr_t               r_commit;
    logic                 r_illegal;

    logic [NumReq-1:0]    w_gnt;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic                 w_xfer;
    logic                 w_illegal;
    logic                 w_we;
    logic [RegAddrW-1:0]  w_sel_waddr;
    logic [DataWidth-1:0] w_sel_wdata;

    ibex_rr_arbiter #(
        .N (NumReq)
    ) u_rr_arbiter (
        .valid_i   (req_valid_i),
        .rr_i      (r_rr_q),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    assign req_ready_o = rst_ni ? w_gnt : '0;
    assign w_xfer      = |(req_valid_i & req_ready_o);

    always_comb begin
        w_sel_waddr = '0;
        w_sel_wdata = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (w_gnt[k]) begin
                w_sel_waddr = req_waddr_i[k*RegAddrW +: RegAddrW];
                w_sel_wdata = req_wdata_i[k*DataWidth +: DataWidth];
            end
        end
    end

    // x0 and out-of-range RV32E writes still handshake but never reach the array.
    assign w_illegal = RV32E && w_sel_waddr[RegAddrW-1];
    assign w_we      = w_xfer && (w_sel_waddr != '0) && !w_illegal;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_q    <= '0;
            r_out     <= '0;
            r_commit  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_commit  <= r_out;
            r_out.we  <= w_we;
            r_illegal <= w_xfer && w_illegal;
            if (w_xfer) begin
                r_rr_q      <= c_IDX_W'((int'(w_gnt_idx) + 1) % NumReq);
                r_out.waddr <= w_sel_waddr;
                r_out.wdata <= w_sel_wdata;
            end
        end
    end

    assign rf_we_o         = r_out.we;
    assign rf_waddr_o      = r_out.waddr;
    assign rf_wdata_o      = r_out.wdata;
    assign illegal_waddr_o = r_illegal;

    // Output stage is newer than commit stage, so it is checked first.
    function automatic logic [DataWidth-1:0] bypass(
        input logic [RegAddrW-1:0]  raddr,
        input logic [DataWidth-1:0] raw,
        input rf_wr_t               out_st,
        input rf_wr_t               com_st
    );
        logic [c_ADDR_W-1:0] ra;
        ra = raddr[c_ADDR_W-1:0];
        if (out_st.we && (out_st.waddr[c_ADDR_W-1:0] == ra) && (ra != '0)) begin
            return out_st.wdata;
        end
        if (com_st.we && (com_st.waddr[c_ADDR_W-1:0] == ra) && (ra != '0)) begin
            return com_st.wdata;
        end
        return raw;
    endfunction

    assign rdata_a_o = bypass(raddr_a_i, rf_rdata_a_i, r_out, r_commit);
    assign rdata_b_o = bypass(raddr_b_i, rf_rdata_b_i, r_out, r_commit);

endmodule
`default_nettype wire
